// File: rtl/vga_timing_ctrl.sv
// Timing configuration controller for the VGA synchronizer: accepts host timing sets,
// validates them, and swaps them in at a frame boundary behind a synchronizer reset window.
module vga_timing_ctrl #(
    parameter int W         = 10,
    parameter int DEF_HSYNC = 95,
    parameter int DEF_LINE  = 793,
    parameter int DEF_VSYNC = 2,
    parameter int DEF_FRAME = 480,
    parameter int SETTLE    = 4,
    parameter int FCW       = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   col,
    input  logic [W-1:0]   row,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [W-1:0]   cfg_hsync_pos,
    input  logic [W-1:0]   cfg_line_size,
    input  logic [W-1:0]   cfg_vsync_pos,
    input  logic [W-1:0]   cfg_frame_size,
    output logic [W-1:0]   hsync_pos,
    output logic [W-1:0]   line_size,
    output logic [W-1:0]   vsync_pos,
    output logic [W-1:0]   frame_size,
    output logic           sync_rst,
    output logic           frame_start,
    output logic           line_start,
    output logic [FCW-1:0] frame_count,
    output logic           cfg_err,
    output logic           busy
);
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_PENDING, ST_SETTLE} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   hsync_reg, hsync_next, line_reg, line_next;
    logic [W-1:0]   vsync_reg, vsync_next, frame_reg, frame_next;
    logic [W-1:0]   sh_hsync_reg, sh_hsync_next, sh_line_reg, sh_line_next;
    logic [W-1:0]   sh_vsync_reg, sh_vsync_next, sh_frame_reg, sh_frame_next;
    logic [SCW-1:0] settle_cnt_reg, settle_cnt_next;
    logic           sync_rst_reg, sync_rst_next;
    logic           frame_start_reg, frame_start_next;
    logic           line_start_reg, line_start_next;
    logic [FCW-1:0] frame_count_reg, frame_count_next;
    logic           cfg_err_reg, cfg_err_next;
    logic           frame_end, cfg_legal, xfer;

    // sync_rst is still high in RUN for the first cycle after reset, which keeps the host out.
    assign cfg_ready   = (state_reg == ST_RUN) && !sync_rst_reg;
    assign busy        = (state_reg != ST_RUN);
    assign hsync_pos   = hsync_reg;
    assign line_size   = line_reg;
    assign vsync_pos   = vsync_reg;
    assign frame_size  = frame_reg;
    assign sync_rst    = sync_rst_reg;
    assign frame_start = frame_start_reg;
    assign line_start  = line_start_reg;
    assign frame_count = frame_count_reg;
    assign cfg_err     = cfg_err_reg;

    assign frame_end = (col == line_reg - W'(1)) && (row == frame_reg - W'(1));
    assign cfg_legal = (cfg_line_size >= W'(2)) && (cfg_frame_size >= W'(2)) &&
                       (cfg_hsync_pos < cfg_line_size) && (cfg_vsync_pos < cfg_frame_size);
    assign xfer      = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_RUN;
            hsync_reg       <= W'(DEF_HSYNC);
            line_reg        <= W'(DEF_LINE);
            vsync_reg       <= W'(DEF_VSYNC);
            frame_reg       <= W'(DEF_FRAME);
            sh_hsync_reg    <= '0;
            sh_line_reg     <= '0;
            sh_vsync_reg    <= '0;
            sh_frame_reg    <= '0;
            settle_cnt_reg  <= '0;
            sync_rst_reg    <= 1'b1;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_count_reg <= '0;
            cfg_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hsync_reg       <= hsync_next;
            line_reg        <= line_next;
            vsync_reg       <= vsync_next;
            frame_reg       <= frame_next;
            sh_hsync_reg    <= sh_hsync_next;
            sh_line_reg     <= sh_line_next;
            sh_vsync_reg    <= sh_vsync_next;
            sh_frame_reg    <= sh_frame_next;
            settle_cnt_reg  <= settle_cnt_next;
            sync_rst_reg    <= sync_rst_next;
            frame_start_reg <= frame_start_next;
            line_start_reg  <= line_start_next;
            frame_count_reg <= frame_count_next;
            cfg_err_reg     <= cfg_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        hsync_next       = hsync_reg;
        line_next        = line_reg;
        vsync_next       = vsync_reg;
        frame_next       = frame_reg;
        sh_hsync_next    = sh_hsync_reg;
        sh_line_next     = sh_line_reg;
        sh_vsync_next    = sh_vsync_reg;
        sh_frame_next    = sh_frame_reg;
        settle_cnt_next  = settle_cnt_reg;
        sync_rst_next    = sync_rst_reg;
        cfg_err_next     = 1'b0;
        line_start_next  = !sync_rst_reg && (col == '0);
        frame_start_next = line_start_next && (row == '0);
        frame_count_next = frame_count_reg + (frame_start_next ? FCW'(1) : FCW'(0));

        case (state_reg)
            ST_RUN: begin
                sync_rst_next = 1'b0;
                if (xfer) begin
                    if (cfg_legal) begin
                        sh_hsync_next = cfg_hsync_pos;
                        sh_line_next  = cfg_line_size;
                        sh_vsync_next = cfg_vsync_pos;
                        sh_frame_next = cfg_frame_size;
                        state_next    = ST_PENDING;
                    end else begin
                        cfg_err_next  = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_end) begin
                    hsync_next      = sh_hsync_reg;
                    line_next       = sh_line_reg;
                    vsync_next      = sh_vsync_reg;
                    frame_next      = sh_frame_reg;
                    sync_rst_next   = 1'b1;
                    settle_cnt_next = '0;
                    state_next      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg == SCW'(SETTLE - 1)) begin
                    sync_rst_next    = 1'b0;
                    frame_count_next = '0;
                    state_next       = ST_RUN;
                end else begin
                    settle_cnt_next  = settle_cnt_reg + SCW'(1);
                end
            end
            default: state_next = ST_RUN;
        endcase
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: table-driven switch vectors, hand sequences and random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_vga_timing_ctrl;
    localparam int W = 10, FCW = 8, SETTLE = 4;

    logic         clk = 1'b0, rst = 1'b1;
    logic [W-1:0] col = '0, row = '0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_h = '0, cfg_l = '0, cfg_v = '0, cfg_f = '0;
    logic           cfg_ready, sync_rst, frame_start, line_start, cfg_err, busy;
    logic [W-1:0]   hsync_pos, line_size, vsync_pos, frame_size;
    logic [FCW-1:0] frame_count;

    vga_timing_ctrl dut (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_hsync_pos(cfg_h), .cfg_line_size(cfg_l),
        .cfg_vsync_pos(cfg_v), .cfg_frame_size(cfg_f),
        .hsync_pos(hsync_pos), .line_size(line_size),
        .vsync_pos(vsync_pos), .frame_size(frame_size),
        .sync_rst(sync_rst), .frame_start(frame_start), .line_start(line_start),
        .frame_count(frame_count), .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Reference model: active/shadow sets, a pending flag and a settle countdown.
    int  m_h, m_l, m_v, m_f, s_h, s_l, s_v, s_f;
    bit  m_pend, m_boot, m_err, m_ls, m_fs, m_xfer;
    int  m_settle, m_frames;
    bit  sync_mode = 1'b0;
    int  cur_h, cur_l, cur_v, cur_f;

    typedef struct { int h; int l; int v; int f; bit legal; } vec_t;
    vec_t vt[8];

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
            if (errors >= 100) begin
                summary();
                $finish;
            end
        end
    endtask

    function automatic bit m_srst();
        return m_boot || (m_settle > 0);
    endfunction
    function automatic bit m_busy();
        return m_pend || (m_settle > 0);
    endfunction
    function automatic bit legal(input int h, input int l, input int v, input int f);
        return (l >= 2) && (f >= 2) && (h < l) && (v < f);
    endfunction

    task automatic model_reset();
        m_h = 95; m_l = 793; m_v = 2; m_f = 480;
        m_pend = 0; m_settle = 0; m_boot = 1; m_frames = 0;
        m_err = 0; m_ls = 0; m_fs = 0; m_xfer = 0;
    endtask

    task automatic model_edge();
        bit srst0, ready0, fe;
        srst0  = m_srst();
        ready0 = !m_busy() && !srst0;
        fe     = (int'(col) == m_l - 1) && (int'(row) == m_f - 1);
        m_ls   = !srst0 && (col == 0);
        m_fs   = m_ls && (row == 0);
        m_err  = 0;
        m_xfer = ready0 && cfg_valid;
        if (m_fs) m_frames = (m_frames + 1) % (1 << FCW);
        m_boot = 0;
        if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) m_frames = 0;
        end else if (m_pend) begin
            if (fe) begin
                m_h = s_h; m_l = s_l; m_v = s_v; m_f = s_f;
                m_pend = 0; m_settle = SETTLE;
            end
        end else if (m_xfer) begin
            if (legal(int'(cfg_h), int'(cfg_l), int'(cfg_v), int'(cfg_f))) begin
                s_h = int'(cfg_h); s_l = int'(cfg_l); s_v = int'(cfg_v); s_f = int'(cfg_f);
                m_pend = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("hsync_pos", int'(hsync_pos), m_h);
        chk("line_size", int'(line_size), m_l);
        chk("vsync_pos", int'(vsync_pos), m_v);
        chk("frame_size", int'(frame_size), m_f);
        chk("sync_rst", int'(sync_rst), int'(m_srst()));
        chk("busy", int'(busy), int'(m_busy()));
        chk("cfg_ready", int'(cfg_ready), int'(!m_busy() && !m_srst()));
        chk("cfg_err", int'(cfg_err), int'(m_err));
        chk("line_start", int'(line_start), int'(m_ls));
        chk("frame_start", int'(frame_start), int'(m_fs));
        chk("frame_count", int'(frame_count), m_frames);
    endtask

    // One clock: advance the model (and the synchronizer stand-in when enabled), then compare.
    task automatic tick();
        int nc, nr;
        @(posedge clk);
        if (m_srst() || !rst) begin
            nc = 0; nr = 0;
        end else begin
            nc = int'(col) + 1; nr = int'(row);
            if (nc >= m_l) begin
                nc = 0; nr = nr + 1;
                if (nr >= m_f) nr = 0;
            end
        end
        if (!rst) model_reset(); else model_edge();
        #1;
        compare_all();
        if (sync_mode) begin
            col = W'(nc); row = W'(nr);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 3000) begin tick(); n++; end
        if (!cfg_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    task automatic offer(input int h, input int l, input int v, input int f);
        wait_ready();
        cfg_h = W'(h); cfg_l = W'(l); cfg_v = W'(v); cfg_f = W'(f);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic chk_active(input string name, input int h, input int l, input int v, input int f);
        chk({name, "_h"}, int'(hsync_pos), h);
        chk({name, "_l"}, int'(line_size), l);
        chk({name, "_v"}, int'(vsync_pos), v);
        chk({name, "_f"}, int'(frame_size), f);
    endtask

    initial begin
        int n, lines, nfs, prev_fc;
        bit saw_wrap;

        vt[0] = '{3, 20, 1, 10, 1'b1};
        vt[1] = '{25, 20, 1, 10, 1'b0};
        vt[2] = '{0, 1, 0, 10, 1'b0};
        vt[3] = '{0, 2, 0, 1, 1'b0};
        vt[4] = '{1, 2, 1, 2, 1'b1};
        vt[5] = '{5, 20, 10, 10, 1'b0};
        vt[6] = '{0, 0, 0, 0, 1'b0};
        vt[7] = '{19, 20, 9, 10, 1'b1};

        // Reset and release
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        chk("rst_sync_rst", int'(sync_rst), 1);
        chk("rst_cfg_ready", int'(cfg_ready), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk_active("rst_def", 95, 793, 2, 480);
        chk("rel_sync_rst", int'(sync_rst), 0);
        chk("rel_cfg_ready", int'(cfg_ready), 1);
        chk("rel_frame_count", int'(frame_count), 0);
        cur_h = 95; cur_l = 793; cur_v = 2; cur_f = 480;

        // Table-driven timing sets; the transfer cycle itself sits on a frame end
        for (int i = 0; i < 8; i++) begin
            sync_mode = 1'b0;
            wait_ready();
            col = W'(cur_l - 1); row = W'(cur_f - 1);
            offer(vt[i].h, vt[i].l, vt[i].v, vt[i].f);
            chk("vec_err", int'(cfg_err), int'(!vt[i].legal));
            chk("vec_busy", int'(busy), int'(vt[i].legal));
            chk("vec_ready", int'(cfg_ready), int'(!vt[i].legal));
            if (vt[i].legal) begin
                col = W'(1); row = '0;
                tick();
                chk_active("vec_hold", cur_h, cur_l, cur_v, cur_f);
                chk("vec_pending", int'(busy), 1);
                col = W'(cur_l - 1); row = W'(cur_f - 1);
                tick();
                chk_active("vec_new", vt[i].h, vt[i].l, vt[i].v, vt[i].f);
                cur_h = vt[i].h; cur_l = vt[i].l; cur_v = vt[i].v; cur_f = vt[i].f;
                sync_mode = 1'b1;
                n = 0;
                if (sync_rst) n = 1;
                for (int k = 0; k < 50 && sync_rst; k++) begin
                    tick();
                    if (sync_rst) n++;
                end
                chk("settle_len", n, SETTLE);
                chk("settle_ready", int'(cfg_ready), 1);
                n = 0;
                while (!frame_start && n < 500) begin tick(); n++; end
                chk("first_frame_start", int'(frame_start), 1);
                chk("first_frame_count", int'(frame_count), 1);
            end else begin
                chk_active("vec_unchanged", cur_h, cur_l, cur_v, cur_f);
            end
        end

        // Back-pressure: a second set held on valid during PENDING waits for busy to fall
        sync_mode = 1'b1;
        offer(2, 16, 3, 8);
        chk("bp_busy", int'(busy), 1);
        cfg_h = W'(4); cfg_l = W'(12); cfg_v = W'(2); cfg_f = W'(6);
        cfg_valid = 1'b1;
        wait_idle();
        chk_active("bp_first", 2, 16, 3, 8);
        chk("bp_ready", int'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        chk("bp_second_busy", int'(busy), 1);
        wait_idle();
        chk_active("bp_second", 4, 12, 2, 6);

        // Reset on the second settle cycle
        offer(7, 24, 4, 12);
        n = 0;
        while (!sync_rst && n < 500) begin tick(); n++; end
        chk("ms_entered_settle", int'(sync_rst), 1);
        tick();
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        chk_active("ms_def", 95, 793, 2, 480);
        chk("ms_busy", int'(busy), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("ms_rel_busy", int'(busy), 0);
        chk("ms_rel_sync_rst", int'(sync_rst), 0);
        chk_active("ms_not_applied", 95, 793, 2, 480);

        // Frame counter wrap on a 20x10 frame
        offer(3, 20, 1, 10);
        sync_mode = 1'b0;
        col = W'(792); row = W'(479);
        tick();
        sync_mode = 1'b1;
        lines = 0; nfs = 0; saw_wrap = 0;
        for (int k = 0; k < 60000 && nfs < 257; k++) begin
            prev_fc = int'(frame_count);
            tick();
            if (frame_start) begin
                if (nfs > 0) chk("lines_per_frame", lines, 10);
                lines = 0;
                nfs++;
                if (prev_fc == 255) begin
                    chk("fc_wrap", int'(frame_count), 0);
                    saw_wrap = 1;
                end
            end
            if (line_start) lines++;
        end
        chk("wrap_seen", int'(saw_wrap), 1);

        // Random traffic against the model
        sync_mode = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 7))
                0: begin col = W'(m_l - 1); row = W'(m_f - 1); end
                1: begin col = '0; row = '0; end
                2: begin col = '0; row = W'($urandom_range(0, m_f - 1)); end
                default: begin
                    col = W'($urandom_range(0, m_l - 1));
                    row = W'($urandom_range(0, m_f - 1));
                end
            endcase
            if (!cfg_valid && $urandom_range(0, 3) == 0) begin
                cfg_h = W'($urandom_range(0, 31));
                cfg_l = W'($urandom_range(0, 30));
                cfg_v = W'($urandom_range(0, 15));
                cfg_f = W'($urandom_range(0, 15));
                cfg_valid = 1'b1;
            end
            tick();
            if (m_xfer) cfg_valid = 1'b0;
        end

        summary();
        $finish;
    end
endmodule
